// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage (OP, OP-IMM, LUI) between
// fetch and execute.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   fetch handshake; in_ready = !flush && (!out_valid || out_ready)
//   instr               32-bit instruction word
//   flush               synchronous flush: drops held bundle and presented instr
//   out_valid/out_ready execute handshake
//   alu_op              0 add,1 xor,2 or,3 and,4 sll,5 srl,6 sra,7 slt,8 sltu,9 sub
//   rs1_addr, rs2_addr, rd_addr, imm, use_imm, reg_we, illegal
//   illegal_cnt         saturating count of accepted, unflushed illegal instrs
module decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic [31:0]      imm,
  output logic             use_imm,
  output logic             reg_we,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_XOR  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SUB  = 4'd9;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        illegal;
  } bundle_t;

  bundle_t    dec, q;
  logic [0:0] vld_pipe;
  logic [CNT_W-1:0] cnt;
  logic       accept;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // Combinational decode of the presented instruction.
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    unique case (opc)
      OPC_OP: begin
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.reg_we = 1'b1;
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          unique case (f3)
            3'b000: dec.alu_op = ALU_ADD;
            3'b001: dec.alu_op = ALU_SLL;
            3'b010: dec.alu_op = ALU_SLT;
            3'b011: dec.alu_op = ALU_SLTU;
            3'b100: dec.alu_op = ALU_XOR;
            3'b101: dec.alu_op = ALU_SRL;
            3'b110: dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          // Only add/srl have an alternate (sub/sra) encoding.
          if (f3 == 3'b000) begin
            legal      = 1'b1;
            dec.alu_op = ALU_SUB;
          end else if (f3 == 3'b101) begin
            legal      = 1'b1;
            dec.alu_op = ALU_SRA;
          end
        end
      end
      OPC_OP_IMM: begin
        dec.rs1     = instr[19:15];
        dec.rd      = instr[11:7];
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
        dec.imm     = {{20{instr[31]}}, instr[31:20]};
        unique case (f3)
          3'b000: begin legal = 1'b1; dec.alu_op = ALU_ADD;  end
          3'b010: begin legal = 1'b1; dec.alu_op = ALU_SLT;  end
          3'b011: begin legal = 1'b1; dec.alu_op = ALU_SLTU; end
          3'b100: begin legal = 1'b1; dec.alu_op = ALU_XOR;  end
          3'b110: begin legal = 1'b1; dec.alu_op = ALU_OR;   end
          3'b111: begin legal = 1'b1; dec.alu_op = ALU_AND;  end
          3'b001: begin
            // Shift immediates carry only the 5-bit shamt.
            dec.imm    = {27'b0, instr[24:20]};
            dec.alu_op = ALU_SLL;
            legal      = (f7 == 7'b0000000);
          end
          default: begin // 3'b101
            dec.imm = {27'b0, instr[24:20]};
            if (f7 == 7'b0000000) begin
              legal      = 1'b1;
              dec.alu_op = ALU_SRL;
            end else if (f7 == 7'b0100000) begin
              legal      = 1'b1;
              dec.alu_op = ALU_SRA;
            end
          end
        endcase
      end
      OPC_LUI: begin
        legal       = 1'b1;
        dec.rd      = instr[11:7];
        dec.imm     = {instr[31:12], 12'b0};
        dec.alu_op  = ALU_ADD;
        dec.use_imm = 1'b1;
        dec.reg_we  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal instructions travel as an all-zero bubble with only the flag set.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = !flush && (!vld_pipe[0] || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      q        <= '0;
      cnt      <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (accept) begin
      vld_pipe <= 1'b1;
      q        <= dec;
      if (dec.illegal && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + 1'b1;
    end else if (out_ready) begin
      vld_pipe <= '0;
    end
  end

  assign out_valid   = vld_pipe[0];
  assign alu_op      = q.alu_op;
  assign rs1_addr    = q.rs1;
  assign rs2_addr    = q.rs2;
  assign rd_addr     = q.rd;
  assign imm         = q.imm;
  assign use_imm     = q.use_imm;
  assign reg_we      = q.reg_we;
  assign illegal     = q.illegal;
  assign illegal_cnt = cnt;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, imm;
  logic [3:0]  alu_op;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        use_imm, reg_we, illegal;
  logic [CW-1:0] illegal_cnt;

  decode_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .use_imm(use_imm), .reg_we(reg_we), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ui, we, il;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    exp_t        e;
  } vec_t;

  int total = 0;
  int bad   = 0;
  exp_t held[$];
  int mcnt = 0;

  // Reference decoder straight from the ISA tables.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t r;
    int   f3, f7, op;
    int   base_map[8];
    bit   ok;
    base_map = '{0, 4, 7, 8, 1, 5, 2, 3}; // indexed by funct3: add sll slt sltu xor srl or and
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    r = '0; ok = 0;
    if (op == 'h33) begin
      r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7]; r.we = 1;
      if (f7 == 0) begin ok = 1; r.op = 4'(base_map[f3]); end
      else if (f7 == 'h20 && f3 == 0) begin ok = 1; r.op = 9; end
      else if (f7 == 'h20 && f3 == 5) begin ok = 1; r.op = 6; end
    end else if (op == 'h13) begin
      r.rs1 = w[19:15]; r.rd = w[11:7]; r.we = 1; r.ui = 1;
      if (f3 == 1 || f3 == 5) begin
        r.imm = 32'(w[24:20]);
        if (f7 == 0) begin ok = 1; r.op = 4'(base_map[f3]); end
        else if (f7 == 'h20 && f3 == 5) begin ok = 1; r.op = 6; end
      end else begin
        ok = 1; r.op = 4'(base_map[f3]);
        r.imm = 32'($signed(w) >>> 20);
      end
    end else if (op == 'h37) begin
      ok = 1; r.rd = w[11:7]; r.we = 1; r.ui = 1;
      r.imm = w & 32'hFFFFF000;
    end
    if (!ok) begin r = '0; r.il = 1; end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] act_bundle();
    exp_t a;
    a = '{alu_op, rs1_addr, rs2_addr, rd_addr, imm, use_imm, reg_we, illegal};
    return 64'(a);
  endfunction

  task automatic check_out();
    chk("out_valid", out_valid, held.size() > 0);
    if (held.size() > 0) chk("bundle", act_bundle(), 64'(held[0]));
    chk("illegal_cnt", illegal_cnt, mcnt);
  endtask

  // Drive one cycle at the negedge, check in_ready, advance the model,
  // then check outputs at the following negedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    logic acc, exp_rdy;
    exp_t nb;
    in_valid = v; instr = ins; out_ready = rdy; flush = fl;
    #1;
    exp_rdy = !fl && (held.size() == 0 || rdy);
    chk("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    if (fl) held.delete();
    else begin
      if (held.size() > 0 && rdy) void'(held.pop_front());
      if (acc) begin
        nb = ref_dec(ins);
        held.push_back(nb);
        if (nb.il && mcnt != CMAX) mcnt++;
      end
    end
    @(negedge clk);
    check_out();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] a, b, d;
    logic [6:0] op;
    int k;
    k = $urandom_range(0, 4);
    a = 5'($urandom); b = 5'($urandom); d = 5'($urandom); f3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case (k)
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h37;
      3: op = 7'h13;
      default: op = 7'($urandom);
    endcase
    if (k == 3) return $urandom; // fully random word
    return {f7, b, a, f3, d, op};
  endfunction

  vec_t tbl[6];

  initial begin
    rst = 1; in_valid = 0; instr = 0; flush = 0; out_ready = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bundle", act_bundle(), 0);
    chk("rst_cnt", illegal_cnt, 0);
    @(negedge clk); rst = 0;

    tbl[0] = '{32'h002081B3, '{4'd0, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 1'b1, 1'b0}};
    tbl[1] = '{32'h407302B3, '{4'd9, 5'd6, 5'd7, 5'd5, 32'h0,        1'b0, 1'b1, 1'b0}};
    tbl[2] = '{32'hFFF00093, '{4'd0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0}};
    tbl[3] = '{32'h40415113, '{4'd6, 5'd2, 5'd0, 5'd2, 32'h4,        1'b1, 1'b1, 1'b0}};
    tbl[4] = '{32'h12345237, '{4'd0, 5'd0, 5'd0, 5'd4, 32'h12345000, 1'b1, 1'b1, 1'b0}};
    tbl[5] = '{32'h00000000, '{4'd0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1}};

    // Back-to-back table vectors, one result per cycle.
    for (int i = 0; i < 6; i++) begin
      step(1, tbl[i].ins, 1, 0);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_bundle", act_bundle(), 64'(tbl[i].e));
    end
    chk("tbl_cnt", illegal_cnt, 1);

    // Flushed illegal is dropped and not counted.
    step(1, 32'hFFFFFFFF, 1, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", illegal_cnt, 1);

    // Backpressure: hold 3 cycles with sub pending.
    step(1, 32'h002081B3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h407302B3, 0, 0);
      chk("bp_hold_rd", rd_addr, 3);
      chk("bp_hold_op", alu_op, 0);
    end
    step(1, 32'h407302B3, 1, 0);
    chk("bp_release_op", alu_op, 9);
    step(0, 32'h0, 1, 0);
    chk("drain_valid", out_valid, 0);

    // Async reset while a bundle is held under backpressure.
    step(1, 32'h00000000, 1, 0);
    step(1, 32'h002081B3, 0, 0);
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_bundle", act_bundle(), 0);
    chk("arst_cnt", illegal_cnt, 0);
    held.delete(); mcnt = 0;
    @(negedge clk); rst = 0; in_valid = 0;
    @(negedge clk);
    check_out();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) == 0);

    // Saturation of the illegal counter.
    for (int i = 0; i < CMAX + 4; i++) step(1, 32'h0000007F, 1, 0);
    chk("sat_cnt", illegal_cnt, CMAX);
    step(1, 32'h00000000, 1, 0);
    chk("sat_cnt2", illegal_cnt, CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
